// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one outstanding word read at a
// time, and hands instructions to decode through a one-entry output buffer.
// Handles delayed branches/jumps from ID, immediate eret/exception redirects,
// and drops responses that belong to a fetch overtaken by a redirect.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'hBFC0_0000,
    parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        BranchD,
    input  logic        Jump,
    input  logic        JumpReg,
    input  logic [31:0] Branch_addr,
    input  logic [31:0] Jump_addr,
    input  logic [31:0] PCSrc_reg,
    input  logic        EPC_sel,
    input  logic [31:0] EPCout,
    input  logic        exception_flush,
    input  logic        StallD,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    output logic [31:0] instr,
    output logic [31:0] PCin,
    output logic [31:0] pc_plus_4,
    output logic        valid_D,
    output logic        adel_D
);

    typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pcin_q, pcin_d;
    logic [31:0] tgt_q, tgt_d;
    logic        valid_q, valid_d;
    logic        adel_q, adel_d;
    logic        discard_q, discard_d;
    logic        pend_q, pend_d;

    logic        consume, buf_free, aligned, accept, id_redir, flush_any;
    logic [31:0] id_tgt, slot_pc, seq_next_pc, flush_tgt;

    assign consume     = valid_q && !StallD;
    assign buf_free    = !valid_q || consume;
    assign aligned     = (pc_q[1:0] == 2'b00);
    // A request is only raised when the buffer can take its response, so the
    // buffer is always empty while a fetch is outstanding.
    assign inst_req    = rst && (state_q == StReq) && buf_free && aligned;
    assign inst_addr   = pc_q;
    assign accept      = inst_req && inst_addr_ok;
    assign id_redir    = valid_q && !StallD && (JumpReg || Jump || BranchD);
    assign id_tgt      = JumpReg ? PCSrc_reg : (Jump ? Jump_addr : Branch_addr);
    assign slot_pc     = pcin_q + 32'd4;
    assign seq_next_pc = pend_q ? tgt_q : pc_q + 32'd4;
    assign flush_any   = exception_flush || EPC_sel;
    assign flush_tgt   = exception_flush ? EXC_VECTOR : EPCout;

    assign instr     = instr_q;
    assign PCin      = pcin_q;
    assign pc_plus_4 = pcin_q + 32'd4;
    assign valid_D   = valid_q;
    assign adel_D    = adel_q;

    // Next-state: fetch FSM, buffer fill/drain, then redirects in rising priority.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        fetch_pc_d = fetch_pc_q;
        instr_d    = instr_q;
        pcin_d     = pcin_q;
        tgt_d      = tgt_q;
        valid_d    = valid_q;
        adel_d     = adel_q;
        discard_d  = discard_q;
        pend_d     = pend_q;

        if (consume) begin
            valid_d = 1'b0;
        end

        case (state_q)
            StReq: begin
                if (buf_free) begin
                    if (!aligned) begin
                        // Misaligned PC: deliver an AdEL entry and park until redirected.
                        instr_d = 32'h0;
                        pcin_d  = pc_q;
                        valid_d = 1'b1;
                        adel_d  = 1'b1;
                        state_d = StIdle;
                    end else if (accept) begin
                        state_d    = StWait;
                        fetch_pc_d = pc_q;
                        pc_d       = seq_next_pc;
                        pend_d     = 1'b0;
                    end
                end
            end
            StWait: begin
                if (inst_data_ok) begin
                    if (discard_q) begin
                        discard_d = 1'b0;
                    end else begin
                        instr_d = inst_rdata;
                        pcin_d  = fetch_pc_q;
                        valid_d = 1'b1;
                        adel_d  = 1'b0;
                    end
                    state_d = StReq;
                end
            end
            default: ;
        endcase

        // Delayed redirect: if the delay slot is not yet accepted, hold the
        // target until it is; otherwise steer the PC now.
        if (id_redir) begin
            if ((pc_q == slot_pc) && !accept) begin
                pend_d = 1'b1;
                tgt_d  = id_tgt;
            end else begin
                pc_d   = id_tgt;
                pend_d = 1'b0;
                if (state_q == StIdle) begin
                    state_d = StReq;
                end
            end
        end

        // Exception flush / eret: no delay slot, kill everything in flight.
        if (flush_any) begin
            pc_d    = flush_tgt;
            valid_d = 1'b0;
            adel_d  = 1'b0;
            pend_d  = 1'b0;
            case (state_q)
                StWait:  discard_d = !inst_data_ok;
                StReq: begin
                    // An address accepted this very cycle still owes a response.
                    state_d   = accept ? StWait : StReq;
                    discard_d = accept;
                end
                default: state_d = StReq;
            endcase
        end
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StReq;
            pc_q       <= RESET_PC;
            fetch_pc_q <= RESET_PC;
            instr_q    <= 32'h0;
            pcin_q     <= 32'h0;
            tgt_q      <= 32'h0;
            valid_q    <= 1'b0;
            adel_q     <= 1'b0;
            discard_q  <= 1'b0;
            pend_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            fetch_pc_q <= fetch_pc_d;
            instr_q    <= instr_d;
            pcin_q     <= pcin_d;
            tgt_q      <= tgt_d;
            valid_q    <= valid_d;
            adel_q     <= adel_d;
            discard_q  <= discard_d;
            pend_q     <= pend_d;
        end
    end

endmodule
